// File: rtl/grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wb_arbiter
//
// Write-port arbiter for the single-write-port general register file.
// The W-stage writeback always wins the port and is never stalled. Results
// from the multicycle unit (mul/div, late loads) are queued in a small FIFO
// and drained into cycles where the W stage does not write. A W-stage write
// to register X kills every queued entry for X, because that queued value is
// older and would otherwise overwrite the newer W-stage result. Killed
// ("dead") entries keep their slot until they reach the head and are popped
// without a write.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   w_we/w_a3/w_wd/w_pc W-stage write request (granted when w_we && w_a3!=0)
//   mu_valid/mu_ready   multicycle result handshake (mu_ready = !full)
//   mu_a3/mu_wd/mu_pc   multicycle result payload
//   grf_we/a3/wd/pc     GRF write port
//   q_a1/q_a2           D-stage hazard query addresses
//   q_pend1/q_pend2     a live queued write targets q_a1 / q_a2
//   count               occupied FIFO slots, live plus dead
// -----------------------------------------------------------------------------
module grf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_we,
  input  logic [4:0]               w_a3,
  input  logic [31:0]              w_wd,
  input  logic [31:0]              w_pc,
  input  logic                     mu_valid,
  output logic                     mu_ready,
  input  logic [4:0]               mu_a3,
  input  logic [31:0]              mu_wd,
  input  logic [31:0]              mu_pc,
  output logic                     grf_we,
  output logic [4:0]               grf_a3,
  output logic [31:0]              grf_wd,
  output logic [31:0]              grf_pc,
  input  logic [4:0]               q_a1,
  input  logic [4:0]               q_a2,
  output logic                     q_pend1,
  output logic                     q_pend2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } entry_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t            entry_q [DEPTH];
  entry_t            entry_d [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  cnt_t              count_q, count_d;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic   w_grant;
  logic   full;
  logic   empty;
  logic   pop;
  logic   push;
  entry_t head;
  logic   head_live;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  // Reset gating keeps the GRF port and the handshake quiet for the whole
  // reset cycle, not just after the clearing edge.
  assign w_grant   = !reset && w_we && (w_a3 != 5'd0);
  assign mu_ready  = !reset && !full;
  assign pop       = !reset && !w_grant && !empty;
  // A handshake for $0 completes but deposits nothing.
  assign push      = mu_valid && mu_ready && (mu_a3 != 5'd0);
  assign head      = entry_q[rd_ptr_q];
  assign head_live = live_q[rd_ptr_q];
  assign count     = count_q;

  // ---------------------------------------------------------------------------
  // GRF write port mux: W stage, then live FIFO head, else idle zeros
  // ---------------------------------------------------------------------------
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    grf_pc = '0;
    if (w_grant) begin
      grf_we = 1'b1;
      grf_a3 = w_a3;
      grf_wd = w_wd;
      grf_pc = w_pc;
    end else if (pop && head_live) begin
      grf_we = 1'b1;
      grf_a3 = head.a3;
      grf_wd = head.wd;
      grf_pc = head.pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard query: only registered live entries count, never the incoming push
  // ---------------------------------------------------------------------------
  always_comb begin
    q_pend1 = 1'b0;
    q_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && entry_q[i].a3 == q_a1) q_pend1 = 1'b1;
      if (live_q[i] && entry_q[i].a3 == q_a2) q_pend2 = 1'b1;
    end
    if (reset || q_a1 == 5'd0) q_pend1 = 1'b0;
    if (reset || q_a2 == 5'd0) q_pend2 = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_d  = entry_q;
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    // WAW squash first, so the same-cycle push below (younger than the W
    // write) is set live afterwards and survives.
    if (w_grant) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_q[i].a3 == w_a3) live_d[i] = 1'b0;
      end
    end

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + ptr_t'(1);
    end

    // Push only happens when not full, so wr_ptr never aliases an occupied
    // slot (including the one being popped).
    if (push) begin
      entry_d[wr_ptr_q] = '{a3: mu_a3, wd: mu_wd, pc: mu_pc};
      live_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d          = wr_ptr_q + ptr_t'(1);
    end

    count_d = count_q + cnt_t'(push) - cnt_t'(pop);

    if (reset) begin
      live_d   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // folded into the _d logic above, so this block is a plain register.
  always_ff @(posedge clk) begin
    live_q   <= live_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

  // NOTE: payload storage is deliberately not reset; a slot is only ever read
  // while its live bit or count says it holds data written by a push.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grf_wb_arbiter
//
// Directed bench for grf_wb_arbiter (DEPTH=2). Inputs change 1 ns after a
// rising edge; outputs are sampled a further 1 ns later, well before the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [31:0] w_pc;
  logic        mu_valid;
  logic        mu_ready;
  logic [4:0]  mu_a3;
  logic [31:0] mu_wd;
  logic [31:0] mu_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        q_pend1;
  logic        q_pend2;
  logic [1:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  grf_wb_arbiter #(.DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .w_we     (w_we),
    .w_a3     (w_a3),
    .w_wd     (w_wd),
    .w_pc     (w_pc),
    .mu_valid (mu_valid),
    .mu_ready (mu_ready),
    .mu_a3    (mu_a3),
    .mu_wd    (mu_wd),
    .mu_pc    (mu_pc),
    .grf_we   (grf_we),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .grf_pc   (grf_pc),
    .q_a1     (q_a1),
    .q_a2     (q_a2),
    .q_pend1  (q_pend1),
    .q_pend2  (q_pend2),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic w_set(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    w_we = we; w_a3 = a3; w_wd = wd; w_pc = pc;
  endtask

  task automatic mu_set(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    mu_valid = v; mu_a3 = a3; mu_wd = wd; mu_pc = pc;
  endtask

  initial begin
    reset = 1'b1;
    w_set(1'b1, 5'd5, 32'hDEAD, 32'h0);
    mu_set(1'b1, 5'd4, 32'h1, 32'h0);
    q_a1 = 5'd0; q_a2 = 5'd0;

    // ---- reset: outputs quiet even with W and mu requesting --------------
    #2;
    check("rst_grf_we", grf_we, 0);
    check("rst_mu_ready", mu_ready, 0);
    tick();
    check("rst_grf_we_2", grf_we, 0);
    reset = 1'b0;
    w_set(1'b0, 5'd0, 32'h0, 32'h0);
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    check("post_rst_count", count, 0);
    check("post_rst_ready", mu_ready, 1);
    check("post_rst_grf_we", grf_we, 0);

    // ---- W passthrough ---------------------------------------------------
    w_set(1'b1, 5'd5, 32'h1234, 32'h100);
    settle();
    check("wpass_we", grf_we, 1);
    check("wpass_a3", grf_a3, 5);
    check("wpass_wd", grf_wd, 32'h1234);
    check("wpass_pc", grf_pc, 32'h100);
    tick();
    check("wpass_count", count, 0);

    // ---- idle drain ------------------------------------------------------
    w_set(1'b0, 5'd0, 32'h0, 32'h0);
    mu_set(1'b1, 5'd7, 32'hAA, 32'h200);
    settle();
    check("drain_ready", mu_ready, 1);
    check("drain_empty_we", grf_we, 0);
    check("drain_empty_a3", grf_a3, 0);
    tick();
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    q_a1 = 5'd7;
    settle();
    check("drain_count1", count, 1);
    check("drain_pend7", q_pend1, 1);
    check("drain_we", grf_we, 1);
    check("drain_a3", grf_a3, 7);
    check("drain_wd", grf_wd, 32'hAA);
    check("drain_pc", grf_pc, 32'h200);
    tick();
    check("drain_count0", count, 0);
    check("drain_idle_we", grf_we, 0);
    check("drain_pend7_gone", q_pend1, 0);

    // ---- backpressure: W writes $3 every cycle ---------------------------
    w_set(1'b1, 5'd3, 32'h33, 32'h300);
    mu_set(1'b1, 5'd10, 32'hB1, 32'h310);
    settle();
    check("bp_w_a3", grf_a3, 3);
    tick();
    check("bp_count1", count, 1);
    mu_set(1'b1, 5'd11, 32'hB2, 32'h320);
    tick();
    check("bp_count2", count, 2);
    check("bp_ready_full", mu_ready, 0);
    // Held request while full and W granted: nothing moves.
    mu_set(1'b1, 5'd12, 32'hB3, 32'h330);
    q_a1 = 5'd10; q_a2 = 5'd11;
    settle();
    check("bp_pend10", q_pend1, 1);
    check("bp_pend11", q_pend2, 1);
    check("bp_w_still", grf_a3, 3);
    tick();
    check("bp_full_hold", count, 2);
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    w_set(1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    check("bp_pop1_we", grf_we, 1);
    check("bp_pop1_a3", grf_a3, 10);
    check("bp_pop1_wd", grf_wd, 32'hB1);
    tick();
    check("bp_pop2_count", count, 1);
    check("bp_pop2_we", grf_we, 1);
    check("bp_pop2_a3", grf_a3, 11);
    check("bp_pop2_wd", grf_wd, 32'hB2);
    check("bp_pop2_pc", grf_pc, 32'h320);
    tick();
    check("bp_count0", count, 0);
    check("bp_idle_we", grf_we, 0);

    // ---- WAW squash ------------------------------------------------------
    q_a1 = 5'd9; q_a2 = 5'd0;
    mu_set(1'b1, 5'd9, 32'h11, 32'h400);
    tick();
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    w_set(1'b1, 5'd9, 32'h22, 32'h410);
    settle();
    check("waw_pend_before", q_pend1, 1);
    check("waw_w_wd", grf_wd, 32'h22);
    tick();
    w_set(1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    check("waw_pend_after", q_pend1, 0);
    check("waw_dead_count", count, 1);
    check("waw_dead_pop_we", grf_we, 0);
    tick();
    check("waw_dead_gone", count, 0);
    // Same-cycle push alongside W write of $9 stays live.
    w_set(1'b1, 5'd9, 32'h33, 32'h420);
    mu_set(1'b1, 5'd9, 32'h44, 32'h430);
    settle();
    check("waw_same_no_pend", q_pend1, 0);
    tick();
    w_set(1'b0, 5'd0, 32'h0, 32'h0);
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    check("waw_same_pend", q_pend1, 1);
    check("waw_same_we", grf_we, 1);
    check("waw_same_a3", grf_a3, 9);
    check("waw_same_wd", grf_wd, 32'h44);
    tick();
    check("waw_same_count0", count, 0);

    // ---- $0 handling -----------------------------------------------------
    q_a1 = 5'd0;
    mu_set(1'b1, 5'd0, 32'h55, 32'h500);
    settle();
    check("zero_ready", mu_ready, 1);
    check("zero_pend", q_pend1, 0);
    tick();
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    check("zero_count", count, 0);
    check("zero_no_we", grf_we, 0);
    mu_set(1'b1, 5'd13, 32'h66, 32'h510);
    tick();
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    w_set(1'b1, 5'd0, 32'h77, 32'h520);
    settle();
    check("zero_w_pop_we", grf_we, 1);
    check("zero_w_pop_a3", grf_a3, 13);
    check("zero_w_pop_wd", grf_wd, 32'h66);
    tick();
    w_set(1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    check("zero_w_count0", count, 0);

    // ---- reset mid-queue -------------------------------------------------
    w_set(1'b1, 5'd3, 32'h33, 32'h600);
    mu_set(1'b1, 5'd14, 32'hC1, 32'h610);
    tick();
    mu_set(1'b1, 5'd15, 32'hC2, 32'h620);
    tick();
    check("rq_count2", count, 2);
    mu_set(1'b0, 5'd0, 32'h0, 32'h0);
    w_set(1'b0, 5'd0, 32'h0, 32'h0);
    q_a1 = 5'd14; q_a2 = 5'd15;
    reset = 1'b1;
    settle();
    check("rq_rst_we", grf_we, 0);
    check("rq_rst_ready", mu_ready, 0);
    check("rq_rst_pend1", q_pend1, 0);
    check("rq_rst_pend2", q_pend2, 0);
    tick();
    reset = 1'b0;
    settle();
    check("rq_count0", count, 0);
    check("rq_ready", mu_ready, 1);
    check("rq_we_after", grf_we, 0);
    check("rq_pend_after", q_pend1, 0);
    tick();
    check("rq_we_later", grf_we, 0);
    check("rq_count_later", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-port arbiter for the general register file in the pipelined core. The GRF has one write port. Two writers share it:
- the W-stage writeback, which must never stall;
- a multicycle unit (mul/div results, late loads), which delivers results through a valid/ready handshake.

The block queues multicycle results in a small FIFO and drains them into idle W-stage cycles. It also squashes queued writes made stale by a younger W-stage write, and reports pending writes to the D-stage hazard logic.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- w_we  in  1  W-stage write enable.
- w_a3  in  5  W-stage destination register.
- w_wd  in  32  W-stage write data.
- w_pc  in  32  W-stage PC, forwarded for trace.
- mu_valid  in  1  multicycle result valid.
- mu_ready  out  1  FIFO can accept; equals !full; low while reset is high.
- mu_a3  in  5  multicycle destination register.
- mu_wd  in  32  multicycle write data.
- mu_pc  in  32  multicycle PC.
- grf_we  out  1  to GRF WE.
- grf_a3  out  5  to GRF A3.
- grf_wd  out  32  to GRF WD3.
- grf_pc  out  32  to GRF pc.
- q_a1  in  5  D-stage query address 1.
- q_a2  in  5  D-stage query address 2.
- q_pend1  out  1  live queued write exists for q_a1.
- q_pend2  out  1  live queued write exists for q_a2.
- count  out  $clog2(DEPTH)+1  occupied FIFO entries, live plus dead.

## Operation
- **W grant:** W stage is granted when w_we && w_a3!=0. The grf_* outputs then mirror w_* combinationally, with zero latency. W-stage writes to $0 produce grf_we=0.
- **FIFO drain:** when W is not granted and the FIFO is non-empty, the head is popped.
  - Live head: grf_we=1, grf_a3/wd/pc = head fields.
  - Dead head: discarded with grf_we=0. One pop per cycle.
- **Idle:** otherwise grf_we=0; grf_a3/wd/pc are 0.
- **Push:** on mu_valid && mu_ready, the entry is enqueued live at the tail. If mu_a3==0, the handshake completes but nothing is enqueued.
- **Push/pop:** push and pop in the same cycle are allowed whenever not full. mu_ready depends on registered count only, never on the same-cycle pop.
- **WAW squash:** when W is granted with address X, every FIFO entry already stored with a3==X is marked dead in that cycle.
  - An entry pushed in the same cycle is younger and is never squashed.
  - Dead entries still occupy slots until popped.
- **Pending query:** q_pendN = (q_aN!=0) && some stored live entry has a3==q_aN. It is combinational from registered state. Same-cycle incoming pushes are excluded.
- **Ordering:** live entries drain in FIFO order.
- **No fairness guarantee:** the multicycle path may wait indefinitely under continuous W writes. The pipeline guarantees W idle cycles.

## Timing
- **Reset values:** reset high clears the FIFO. After the reset edge: count=0, all entries dead/empty.
- **Outputs while reset is high:** grf_we=0, mu_ready=0, q_pend1=q_pend2=0.
- **Reset mid-operation:** queued writes are lost and none reach the GRF.
- **Latency:**
  - W path: 0 cycles, same cycle.
  - Multicycle path: at least 1 cycle, i.e. pushed at edge t, earliest grf_we in cycle t+1.
- **Full:** count==DEPTH gives mu_ready=0; a mu_valid held high waits.
- **Empty:** count==0 with no W grant gives grf_we=0.
- **Pointer wrap:** pointers wrap modulo DEPTH; count distinguishes full from empty.
- **Simultaneous W grant and full FIFO:** no pop and no push; state holds except the squash.

## Test plan
- **W passthrough:** w_we=1, w_a3=5, w_wd=0x1234 -> grf_we=1, grf_a3=5, grf_wd=0x1234 in the same cycle; count stays 0.
- **Idle drain:** push (a3=7, wd=0xAA) with w_we=0 -> next cycle grf_we=1, grf_a3=7, grf_wd=0xAA; count returns to 0.
- **Backpressure:** push 2 entries while W writes $3 every cycle -> count=2, mu_ready=0, q_pend for those addresses =1. Drop w_we -> entries appear on grf_* in push order over 2 cycles.
- **WAW squash:**
  - Queue (a3=9, 0x11).
  - Next cycle W writes $9 with 0x22 -> q_pend(9)=0.
  - Next idle cycle pops the dead head with grf_we=0; the GRF keeps 0x22.
  - A same-cycle push of a3=9 alongside a W write of $9 stays live.
- **$0 handling:** mu push with a3=0 -> handshake completes, count unchanged. W write with a3=0 and a queued entry -> the queued entry pops that cycle.
- **Reset mid-queue:** 2 queued entries, assert reset for 1 cycle -> grf_we=0 throughout; count=0 and mu_ready=1 after the reset edge; no stale writes afterwards.
